// File: rtl/aes_chain_if.sv
// Bus-side and core-side signal bundle for the AES block-chaining front end.
// The controller connects through the slave modport; the driving environment
// (bus shift path plus AES round core) uses the master modport.
interface aes_chain_if #(
  parameter int BUS_W = 32
);
  // Mode configuration
  logic [1:0]       mode;
  logic             encrypt;
  logic [127:0]     iv;
  logic             iv_load;
  // Input word stream
  logic             in_valid;
  logic [BUS_W-1:0] in_data;
  logic             in_ready;
  // AES round core handshake
  logic             core_start;
  logic             core_encrypt;
  logic [127:0]     core_block;
  logic             core_done;
  logic [127:0]     core_result;
  // Output word stream
  logic             out_valid;
  logic [BUS_W-1:0] out_data;
  logic             out_ready;
  // Status
  logic             busy;
  logic [15:0]      blocks_done;
  logic             err;

  modport slave (
    input  mode, encrypt, iv, iv_load,
    input  in_valid, in_data,
    output in_ready,
    output core_start, core_encrypt, core_block,
    input  core_done, core_result,
    output out_valid, out_data,
    input  out_ready,
    output busy, blocks_done, err
  );

  modport master (
    output mode, encrypt, iv, iv_load,
    output in_valid, in_data,
    input  in_ready,
    input  core_start, core_encrypt, core_block,
    output core_done, core_result,
    input  out_valid, out_data,
    output out_ready,
    input  busy, blocks_done, err
  );
endinterface

// File: rtl/aes_chain_ctrl.sv
// Block-chaining front end for the AES accelerator.
// Packs BUS_W-bit words (MSB-first) into 128-bit blocks, applies ECB / CBC /
// CTR chaining around one AES core operation per block and unpacks the
// result back into BUS_W-bit words.
// Optional feature: define AES_CHAIN_WDOG_EN to enable a core_done watchdog
// (TIMEOUT cycles in WAIT); without it err is tied low and WAIT never times out.
module aes_chain_ctrl #(
  parameter int BUS_W   = 32,
  parameter int CTR_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       hclk,
  input  logic       hrst,
  aes_chain_if.slave bus
);

  localparam int WPB   = 128 / BUS_W;
  localparam int CNT_W = 3;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;

  // Low CTR_W bits of the counter block take part in the increment.
  localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                     : ((128'd1 << CTR_W) - 128'd1);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

  // Elaboration-time parameter legality checks.
  if (BUS_W != 32 && BUS_W != 64 && BUS_W != 128) begin : g_bad_bus_w
    $error("aes_chain_ctrl: BUS_W must be 32, 64 or 128");
  end
  if (CTR_W < 1 || CTR_W > 128 || TIMEOUT < 1) begin : g_bad_param
    $error("aes_chain_ctrl: CTR_W must be 1..128 and TIMEOUT at least 1");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [127:0]     blk_reg;
  logic [127:0]     chain_reg;
  logic [127:0]     ctr_reg;
  logic [1:0]       mode_reg;
  logic             enc_reg;
  logic             in_ready_reg;
  logic             core_start_reg;
  logic             core_encrypt_reg;
  logic [127:0]     core_block_reg;
  logic [127:0]     out_blk_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [15:0]      blocks_done_reg;
`ifdef AES_CHAIN_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog_reg;
  logic              err_reg;
`endif

  logic         load_take;
  logic         accept;
  logic         last_word;
  logic         last_out;
  logic [1:0]   mode_norm;
  logic [1:0]   mode_eff;
  logic         enc_eff;
  logic [127:0] chain_eff;
  logic [127:0] ctr_eff;
  logic [127:0] blk_full;
  logic [127:0] out_shift;
  logic [127:0] operand;
  logic [127:0] post_block;
  logic [127:0] ctr_inc;

  // Handshake qualifiers and the "load takes effect first" view of the config.
  assign load_take = (state_reg == FILL) && (cnt_reg == '0) && bus.iv_load;
  assign accept    = (state_reg == FILL) && in_ready_reg && bus.in_valid;
  assign last_word = accept && (cnt_reg == CNT_W'(WPB - 1));
  assign last_out  = bus.out_ready && (cnt_reg == CNT_W'(WPB - 1));
  assign mode_norm = (bus.mode == 2'b11) ? M_ECB : bus.mode;
  assign mode_eff  = load_take ? mode_norm   : mode_reg;
  assign enc_eff   = load_take ? bus.encrypt : enc_reg;
  assign chain_eff = load_take ? bus.iv      : chain_reg;
  assign ctr_eff   = load_take ? bus.iv      : ctr_reg;

  // Word lanes: lane gi occupies bits [127-gi*BUS_W -: BUS_W] (lane 0 is the MSB word).
  for (genvar gi = 0; gi < WPB; gi++) begin : g_lane
    localparam int HI = 127 - gi * BUS_W;
    assign blk_full[HI -: BUS_W] = (cnt_reg == CNT_W'(gi)) ? bus.in_data
                                                           : blk_reg[HI -: BUS_W];
    if (gi == WPB - 1) begin : g_tail
      assign out_shift[HI -: BUS_W] = '0;
    end else begin : g_body
      assign out_shift[HI -: BUS_W] = out_blk_reg[HI - BUS_W -: BUS_W];
    end
  end

  assign ctr_inc = (ctr_reg & ~CTR_MASK) | ((ctr_reg + 128'd1) & CTR_MASK);

  // Core operand built from the completed block, including the word arriving now.
  always_comb begin
    operand = blk_full;
    case (mode_eff)
      M_CBC:   if (enc_eff) operand = blk_full ^ chain_eff;
      M_CTR:   operand = ctr_eff;
      default: ;
    endcase
  end

  // Post-processing of the core result into the output block.
  always_comb begin
    post_block = bus.core_result;
    case (mode_reg)
      M_CBC:   if (!enc_reg) post_block = bus.core_result ^ chain_reg;
      M_CTR:   post_block = bus.core_result ^ blk_reg;
      default: ;
    endcase
  end

  // Main sequencer: FILL -> ISSUE -> WAIT -> DRAIN with registered outputs.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_reg        <= FILL;
      cnt_reg          <= '0;
      blk_reg          <= '0;
      chain_reg        <= '0;
      ctr_reg          <= '0;
      mode_reg         <= M_ECB;
      enc_reg          <= 1'b1;
      in_ready_reg     <= 1'b0;
      core_start_reg   <= 1'b0;
      core_encrypt_reg <= 1'b0;
      core_block_reg   <= '0;
      out_blk_reg      <= '0;
      out_valid_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      blocks_done_reg  <= '0;
`ifdef AES_CHAIN_WDOG_EN
      wdog_reg         <= '0;
      err_reg          <= 1'b0;
`endif
    end else begin
      case (state_reg)
        FILL: begin
          in_ready_reg <= 1'b1;
          if (load_take) begin
            chain_reg <= bus.iv;
            ctr_reg   <= bus.iv;
            mode_reg  <= mode_norm;
            enc_reg   <= bus.encrypt;
          end
          if (accept) begin
            blk_reg <= blk_full;
            if (last_word) begin
              cnt_reg          <= '0;
              state_reg        <= ISSUE;
              in_ready_reg     <= 1'b0;
              busy_reg         <= 1'b1;
              core_start_reg   <= 1'b1;
              core_block_reg   <= operand;
              core_encrypt_reg <= (mode_eff == M_CTR) ? 1'b1 : enc_eff;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ISSUE: begin
          core_start_reg <= 1'b0;
          state_reg      <= WAIT;
`ifdef AES_CHAIN_WDOG_EN
          wdog_reg       <= '0;
`endif
        end
        WAIT: begin
          if (bus.core_done) begin
            out_blk_reg     <= post_block;
            out_valid_reg   <= 1'b1;
            blocks_done_reg <= blocks_done_reg + 16'd1;
            state_reg       <= DRAIN;
            if (mode_reg == M_CBC) chain_reg <= enc_reg ? bus.core_result : blk_reg;
            if (mode_reg == M_CTR) ctr_reg <= ctr_inc;
          end
`ifdef AES_CHAIN_WDOG_EN
          else if (wdog_reg == WDOG_W'(TIMEOUT - 1)) begin
            err_reg      <= 1'b1;
            state_reg    <= FILL;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (bus.out_ready) begin
            out_blk_reg <= out_shift;
            if (last_out) begin
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              in_ready_reg  <= 1'b1;
              state_reg     <= FILL;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.core_start   = core_start_reg;
  assign bus.core_encrypt = core_encrypt_reg;
  assign bus.core_block   = core_block_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_data     = out_blk_reg[127 -: BUS_W];
  assign bus.busy         = busy_reg;
  assign bus.blocks_done  = blocks_done_reg;
`ifdef AES_CHAIN_WDOG_EN
  assign bus.err          = err_reg;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// Directed bench for aes_chain_ctrl (BUS_W=32): table of block vectors plus
// hand-written sequences for back-pressure, reset in WAIT and the watchdog.
// Core stub: core_result = ~core_block, core_done a few cycles after core_start.
module tb_aes_chain_ctrl;
  localparam int BUS_W   = 32;
  localparam int WPB     = 128 / BUS_W;
  localparam int TIMEOUT = 64;

  localparam logic [127:0] D0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DA  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] DB  = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] IVA = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
  localparam logic [127:0] CT  = 128'h00000000_00000000_00000000_FFFFFFFF;
  localparam logic [127:0] CU  = 128'hCAFEBABE_00000000_00000000_FFFFFFFF;
  localparam logic [127:0] PP  = 128'h12345678_00000000_0000FFFF_A5A5A5A5;
  localparam logic [127:0] ONES = {128{1'b1}};

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic         enc;
    logic [127:0] iv;
    bit           load;
    int           late_load;
    logic [127:0] data;
    logic [127:0] exp_core;
    logic         exp_cenc;
    logic [127:0] exp_out;
    logic [15:0]  exp_bd;
  } vec_t;

  logic hclk = 1'b0;
  logic hrst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   stub_en = 1'b1;
  bit   inject_done = 1'b0;
  int   cd;

  aes_chain_if #(.BUS_W(BUS_W)) bus ();

  aes_chain_ctrl #(.BUS_W(BUS_W), .CTR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  always #5 hclk = ~hclk;

  // AES core stub.
  assign bus.core_result = ~bus.core_block;
  always @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      cd            <= 0;
      bus.core_done <= 1'b0;
    end else begin
      bus.core_done <= inject_done;
      if (bus.core_start && stub_en) cd <= 3;
      else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) bus.core_done <= 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT, expected event", nm);
  endtask

  task automatic put_word(input logic [BUS_W-1:0] w);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 50) begin
      @(negedge hclk);
      t++;
    end
    if (t >= 50) note_timeout("in_ready");
    @(negedge hclk);
    bus.in_valid = 1'b0;
  endtask

  // Feeds one block; returns at the negedge where core_start should be high.
  task automatic feed_block(input vec_t v);
    bus.mode    = v.mode;
    bus.encrypt = v.enc;
    bus.iv      = v.iv;
    for (int k = 0; k < WPB; k++) begin
      bus.iv_load = (k == 0 && v.load) || (v.late_load != 0 && k == v.late_load);
      put_word(v.data[127 - k*BUS_W -: BUS_W]);
    end
    bus.iv_load = 1'b0;
    check("start_latency", {127'd0, bus.core_start}, 128'd1);
    check("busy_issue", {127'd0, bus.busy}, 128'd1);
  endtask

  // Waits for core_done, then drains the output block (optionally stalling).
  task automatic finish_block(input int stall, input logic [127:0] cblk,
                              output logic [127:0] oblk);
    int t = 0;
    logic [BUS_W-1:0] first;
    oblk = '0;
    while (!bus.core_done && t < 100) begin
      @(negedge hclk);
      t++;
    end
    if (t >= 100) begin
      note_timeout("core_done");
      return;
    end
    check("block_hold", bus.core_block, cblk);
    @(negedge hclk);
    check("out_latency", {127'd0, bus.out_valid}, 128'd1);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      first = bus.out_data;
      repeat (stall) begin
        @(negedge hclk);
        check("bp_hold", {96'd0, bus.out_data}, {96'd0, first});
        check("bp_valid", {127'd0, bus.out_valid}, 128'd1);
        check("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < WPB; k++) begin
      t = 0;
      while (!bus.out_valid && t < 20) begin
        @(negedge hclk);
        t++;
      end
      if (t >= 20) begin
        note_timeout("out_valid");
        break;
      end
      oblk[127 - k*BUS_W -: BUS_W] = bus.out_data;
      @(negedge hclk);
    end
    bus.out_ready = 1'b0;
    check("busy_after_drain", {127'd0, bus.busy}, 128'd0);
    check("in_ready_after_drain", {127'd0, bus.in_ready}, 128'd1);
  endtask

  task automatic run_vec(input vec_t v, input int stall);
    logic [127:0] cblk;
    logic         cenc;
    logic [127:0] oblk;
    feed_block(v);
    cblk = bus.core_block;
    cenc = bus.core_encrypt;
    check({v.name, "_core_block"}, cblk, v.exp_core);
    check({v.name, "_core_encrypt"}, {127'd0, cenc}, {127'd0, v.exp_cenc});
    finish_block(stall, cblk, oblk);
    check({v.name, "_out"}, oblk, v.exp_out);
    check({v.name, "_blocks_done"}, {112'd0, bus.blocks_done}, {112'd0, v.exp_bd});
    $display("vec %s: core_block=%h out=%h blocks_done=%0d", v.name, cblk, oblk, bus.blocks_done);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_in_ready"}, {127'd0, bus.in_ready}, 128'd0);
    check({nm, "_core_start"}, {127'd0, bus.core_start}, 128'd0);
    check({nm, "_core_encrypt"}, {127'd0, bus.core_encrypt}, 128'd0);
    check({nm, "_core_block"}, bus.core_block, 128'd0);
    check({nm, "_out_valid"}, {127'd0, bus.out_valid}, 128'd0);
    check({nm, "_out_data"}, {96'd0, bus.out_data}, 128'd0);
    check({nm, "_busy"}, {127'd0, bus.busy}, 128'd0);
    check({nm, "_blocks_done"}, {112'd0, bus.blocks_done}, 128'd0);
    check({nm, "_err"}, {127'd0, bus.err}, 128'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vec_t v;
    logic [127:0] oblk;

    vecs[0]  = '{"ecb",      2'b00, 1'b1, 128'h0, 1'b1, 0, D0, D0, 1'b1,
                 128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'd1};
    vecs[1]  = '{"cbc_e1",   2'b01, 1'b1, ONES, 1'b1, 0, 128'h0, ONES, 1'b1, 128'h0, 16'd2};
    vecs[2]  = '{"cbc_e2",   2'b01, 1'b1, 128'h0, 1'b0, 0, 128'h0, 128'h0, 1'b1, ONES, 16'd3};
    vecs[3]  = '{"cbc_d1",   2'b01, 1'b0, IVA, 1'b1, 0, DA, DA, 1'b0,
                 128'hF1D3B597_795B3D1F_0E2C4A68_86A4C2E0, 16'd4};
    vecs[4]  = '{"cbc_d2",   2'b01, 1'b0, 128'h0, 1'b0, 0, DB, DB, 1'b0,
                 128'h01234567_76543210_FEDCBA98_89ABCDEF, 16'd5};
    vecs[5]  = '{"ctr1",     2'b10, 1'b0, CT, 1'b1, 0, 128'h0, CT, 1'b1,
                 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000, 16'd6};
    vecs[6]  = '{"ctr2",     2'b10, 1'b0, 128'h0, 1'b0, 0, 128'h0, 128'h0, 1'b1, ONES, 16'd7};
    vecs[7]  = '{"ctr3",     2'b10, 1'b1, CU, 1'b1, 0, PP, CU, 1'b1,
                 128'h27351339_FFFFFFFF_FFFF0000_A5A5A5A5, 16'd8};
    vecs[8]  = '{"ctr4",     2'b10, 1'b1, 128'h0, 1'b0, 0, 128'h0,
                 128'hCAFEBABE_00000000_00000000_00000000, 1'b1,
                 128'h35014541_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'd9};
    vecs[9]  = '{"mode3",    2'b11, 1'b0, 128'h0, 1'b1, 0, D0, D0, 1'b0,
                 128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'd10};
    vecs[10] = '{"lateload", 2'b10, 1'b1, ONES, 1'b0, 2, DA, DA, 1'b0,
                 128'hFEDCBA98_76543210_01234567_89ABCDEF, 16'd11};

    bus.mode = 2'b00; bus.encrypt = 1'b1; bus.iv = '0; bus.iv_load = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge hclk);
    check_all_zero("reset");
    hrst = 1'b0;
    @(negedge hclk);
    check("post_reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("post_reset_busy", {127'd0, bus.busy}, 128'd0);

    // Table-driven block vectors.
    for (int i = 0; i < 11; i++) run_vec(vecs[i], 0);

    // Back-pressure: five stalled cycles in DRAIN.
    v = vecs[0];
    v.name = "backpressure";
    v.exp_bd = 16'd12;
    run_vec(v, 5);

    // Reset while waiting for the core.
    v = vecs[0];
    feed_block(v);
    @(negedge hclk);
    hrst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    $display("seq rst_wait: reset applied in WAIT");
    @(negedge hclk);
    hrst = 1'b0;
    @(negedge hclk);
    v.name = "after_rst";
    v.exp_bd = 16'd1;
    run_vec(v, 0);

    // Core never answers: dropped block under the watchdog, indefinite wait without it.
    stub_en = 1'b0;
    v = '{"wdog", 2'b01, 1'b1, IVA, 1'b1, 0, 128'h0, IVA, 1'b1, ~IVA, 16'd1};
    feed_block(v);
`ifdef AES_CHAIN_WDOG_EN
    repeat (TIMEOUT) @(negedge hclk);
    check("wdog_err_early", {127'd0, bus.err}, 128'd0);
    @(negedge hclk);
    check("wdog_err", {127'd0, bus.err}, 128'd1);
    check("wdog_busy", {127'd0, bus.busy}, 128'd0);
    check("wdog_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("wdog_blocks_done", {112'd0, bus.blocks_done}, 128'd1);
    inject_done = 1'b1;
    @(negedge hclk);
    inject_done = 1'b0;
    repeat (2) @(negedge hclk);
    check("late_done_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("late_done_blocks_done", {112'd0, bus.blocks_done}, 128'd1);
    $display("seq wdog: err=%0d blocks_done=%0d", bus.err, bus.blocks_done);
    stub_en = 1'b1;
    // Chain must still be IVA: next zero block encrypts IVA ^ 0.
    v = '{"wdog_next", 2'b01, 1'b1, 128'h0, 1'b0, 0, 128'h0, IVA, 1'b1, ~IVA, 16'd2};
    run_vec(v, 0);
    check("err_sticky", {127'd0, bus.err}, 128'd1);
`else
    repeat (TIMEOUT + 20) @(negedge hclk);
    check("nowdog_err", {127'd0, bus.err}, 128'd0);
    check("nowdog_busy", {127'd0, bus.busy}, 128'd1);
    inject_done = 1'b1;
    @(negedge hclk);
    inject_done = 1'b0;
    stub_en = 1'b1;
    finish_block(0, IVA, oblk);
    check("nowdog_out", oblk, ~IVA);
    check("nowdog_blocks_done", {112'd0, bus.blocks_done}, 128'd2);
    $display("seq nowdog: out=%h blocks_done=%0d", oblk, bus.blocks_done);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
